// File: rtl/lvds_tx_patgen.sv
// Multi-lane LVDS TX test-pattern source: counter / PRBS7 / fixed / walking-one words,
// with synchronised, lane-masked error bursts and a saturating corrupted-word counter.
module lvds_tx_patgen #(
  parameter int         LANES     = 10,
  parameter int         LANE_W    = 8,
  parameter logic [6:0] PRBS_SEED = 7'h7F,
  parameter int         ERR_SYNC  = 2
) (
  input  logic                      TX_CLK,
  input  logic                      TX_RST_N,
  input  logic                      LVDS_INIT_DONE,
  input  logic                      PAT_EN,
  input  logic [1:0]                PAT_MODE,
  input  logic [LANE_W-1:0]         PAT_FIXED,
  input  logic                      ERR_INSERT,
  input  logic [LANES-1:0]          ERR_LANE_MASK,
  input  logic [3:0]                ERR_BURST,
  output logic [LANES*LANE_W-1:0]   TX_DATA,
  output logic                      TX_VALID,
  output logic                      ERR_BUSY,
  output logic [15:0]               ERR_CNT
);

  typedef enum logic [1:0] {
    MODE_CNT   = 2'd0,
    MODE_PRBS  = 2'd1,
    MODE_FIXED = 2'd2,
    MODE_WALK  = 2'd3
  } pat_mode_e;

  function automatic logic [6:0] lfsr_seed(input int lane);
    logic [6:0] s;
    s = PRBS_SEED ^ 7'(lane);
    return (s == 7'd0) ? 7'h01 : s;
  endfunction

  function automatic logic [LANE_W-1:0] walk_seed(input int lane);
    return LANE_W'(1) << (lane % LANE_W);
  endfunction

  function automatic logic [4:0] popcount(input logic [LANES-1:0] m);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < LANES; i++) c = c + 5'(m[i]);
    return c;
  endfunction

  logic                      run;
  pat_mode_e                 mode, mode_q;
  logic                      mode_chg;
  logic [LANE_W-1:0]         cnt_q, cnt_cur;
  logic [6:0]                lfsr_q   [LANES];
  logic [6:0]                lfsr_cur [LANES];
  logic [6:0]                lfsr_nxt [LANES];
  logic [LANE_W-1:0]         walk_q   [LANES];
  logic [LANE_W-1:0]         walk_cur [LANES];
  logic [LANES*LANE_W-1:0]   pat_word, out_word;

  logic [ERR_SYNC-1:0]       sync_q;
  logic                      sync_prev_q;
  logic                      err_edge;
  logic [LANES-1:0]          mask_q;
  logic [4:0]                burst_cnt_q;
  logic                      busy_q;
  logic                      corrupt;
  logic [15:0]               err_cnt_q;
  logic [16:0]               err_sum;

  assign run      = PAT_EN & LVDS_INIT_DONE;
  assign mode     = pat_mode_e'(PAT_MODE);
  assign mode_chg = (mode != mode_q);
  assign err_edge = sync_q[ERR_SYNC-1] & ~sync_prev_q;
  assign corrupt  = busy_q & run;
  assign err_sum  = {1'b0, err_cnt_q} + 17'(popcount(mask_q));

  // A mode change substitutes the initial state, so the first word of the new mode is its seed word.
  always_comb begin : gen_comb
    logic [6:0]        s;
    logic [LANE_W-1:0] pw;
    logic              fb;
    // NOTE: every variable gets a default before any branch so no latch can be inferred.
    s        = '0;
    pw       = '0;
    fb       = 1'b0;
    pat_word = '0;
    out_word = '0;
    cnt_cur  = mode_chg ? '0 : cnt_q;
    for (int i = 0; i < LANES; i++) begin
      lfsr_cur[i] = mode_chg ? lfsr_seed(i) : lfsr_q[i];
      walk_cur[i] = mode_chg ? walk_seed(i) : walk_q[i];
      s = lfsr_cur[i];
      for (int b = LANE_W - 1; b >= 0; b--) begin
        fb    = s[6] ^ s[5];
        pw[b] = fb;
        s     = {s[5:0], fb};
      end
      lfsr_nxt[i] = s;
      case (mode)
        MODE_CNT:   pat_word[i*LANE_W +: LANE_W] = cnt_cur + LANE_W'(i);
        MODE_PRBS:  pat_word[i*LANE_W +: LANE_W] = pw;
        MODE_FIXED: pat_word[i*LANE_W +: LANE_W] = PAT_FIXED;
        MODE_WALK:  pat_word[i*LANE_W +: LANE_W] = walk_cur[i];
        default:    pat_word[i*LANE_W +: LANE_W] = '0;
      endcase
      out_word[i*LANE_W +: LANE_W] = pat_word[i*LANE_W +: LANE_W]
                                   ^ LANE_W'(corrupt & mask_q[i]);
    end
  end

  always_ff @(posedge TX_CLK or negedge TX_RST_N) begin
    if (!TX_RST_N) begin
      mode_q   <= MODE_CNT;
      cnt_q    <= '0;
      TX_DATA  <= '0;
      TX_VALID <= 1'b0;
      // NOTE: generator arrays are reset element by element; their reset value is the pattern seed.
      for (int i = 0; i < LANES; i++) begin
        lfsr_q[i] <= lfsr_seed(i);
        walk_q[i] <= walk_seed(i);
      end
    end else begin
      // NOTE: non-blocking assignments keep every register reading the pre-edge values.
      mode_q   <= mode;
      TX_VALID <= run;
      if (run) begin
        cnt_q   <= cnt_cur + LANE_W'(1);
        TX_DATA <= out_word;
        for (int i = 0; i < LANES; i++) begin
          lfsr_q[i] <= lfsr_nxt[i];
          walk_q[i] <= {walk_cur[i][LANE_W-2:0], walk_cur[i][LANE_W-1]};
        end
      end else begin
        cnt_q <= cnt_cur;
        for (int i = 0; i < LANES; i++) begin
          lfsr_q[i] <= lfsr_cur[i];
          walk_q[i] <= walk_cur[i];
        end
      end
    end
  end

  // Burst requests arriving while busy (including its last cycle) or with an empty mask are dropped.
  always_ff @(posedge TX_CLK or negedge TX_RST_N) begin
    if (!TX_RST_N) begin
      sync_q      <= '0;
      sync_prev_q <= 1'b0;
      mask_q      <= '0;
      burst_cnt_q <= '0;
      busy_q      <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      sync_q      <= {sync_q[ERR_SYNC-2:0], ERR_INSERT};
      sync_prev_q <= sync_q[ERR_SYNC-1];
      if (corrupt) begin
        burst_cnt_q <= burst_cnt_q - 5'd1;
        if (burst_cnt_q == 5'd1) busy_q <= 1'b0;
        err_cnt_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
      end else if (!busy_q && err_edge && (ERR_LANE_MASK != '0)) begin
        mask_q      <= ERR_LANE_MASK;
        burst_cnt_q <= {1'b0, ERR_BURST} + 5'd1;
        busy_q      <= 1'b1;
      end
    end
  end

  assign ERR_BUSY = busy_q;
  assign ERR_CNT  = err_cnt_q;

endmodule

// File: tb/tb_lvds_tx_patgen.sv
// Directed bench for lvds_tx_patgen (10 lanes x 8 bits): pattern modes, mode switch,
// error bursts, ignored requests, freeze on run=0 and mid-burst reset.
module tb_lvds_tx_patgen;
  localparam int LANES  = 10;
  localparam int LANE_W = 8;

  logic                    TX_CLK = 1'b0;
  logic                    TX_RST_N;
  logic                    LVDS_INIT_DONE;
  logic                    PAT_EN;
  logic [1:0]              PAT_MODE;
  logic [LANE_W-1:0]       PAT_FIXED;
  logic                    ERR_INSERT;
  logic [LANES-1:0]        ERR_LANE_MASK;
  logic [3:0]              ERR_BURST;
  logic [LANES*LANE_W-1:0] TX_DATA;
  logic                    TX_VALID;
  logic                    ERR_BUSY;
  logic [15:0]             ERR_CNT;

  lvds_tx_patgen dut (
    .TX_CLK         (TX_CLK),
    .TX_RST_N       (TX_RST_N),
    .LVDS_INIT_DONE (LVDS_INIT_DONE),
    .PAT_EN         (PAT_EN),
    .PAT_MODE       (PAT_MODE),
    .PAT_FIXED      (PAT_FIXED),
    .ERR_INSERT     (ERR_INSERT),
    .ERR_LANE_MASK  (ERR_LANE_MASK),
    .ERR_BURST      (ERR_BURST),
    .TX_DATA        (TX_DATA),
    .TX_VALID       (TX_VALID),
    .ERR_BUSY       (ERR_BUSY),
    .ERR_CNT        (ERR_CNT)
  );

  always #5 TX_CLK = ~TX_CLK;

  int         checks = 0;
  int         errors = 0;
  int         corr [LANES];
  int         bad;
  int         zeros;
  bit         busy_seen;
  logic [7:0] nxt;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lane(input int i);
    return TX_DATA[i*LANE_W +: LANE_W];
  endfunction

  function automatic int sum_corr();
    int s;
    s = 0;
    for (int i = 0; i < LANES; i++) s += corr[i];
    return s;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge TX_CLK);
  endtask

  task automatic clear_stats();
    for (int i = 0; i < LANES; i++) corr[i] = 0;
    bad       = 0;
    busy_seen = 0;
  endtask

  // One cycle in counter mode: classify each valid lane word against the expected counter.
  task automatic tick();
    logic [7:0] diff;
    @(negedge TX_CLK);
    if (ERR_BUSY) busy_seen = 1;
    if (TX_VALID) begin
      for (int i = 0; i < LANES; i++) begin
        diff = lane(i) ^ (nxt + 8'(i));
        if (diff == 8'h01) corr[i]++;
        else if (diff != 8'h00) bad++;
      end
      nxt = nxt + 8'd1;
    end
  endtask

  task automatic pulse();
    ERR_INSERT = 1'b1;
    tick();
    tick();
    ERR_INSERT = 1'b0;
  endtask

  task automatic wait_busy(input logic lvl, input int budget, input string tag);
    int k;
    k = 0;
    while (ERR_BUSY !== lvl && k < budget) begin
      tick();
      k++;
    end
    check(tag, ERR_BUSY, lvl);
  endtask

  initial begin
    TX_RST_N       = 1'b0;
    LVDS_INIT_DONE = 1'b0;
    PAT_EN         = 1'b0;
    PAT_MODE       = 2'd0;
    PAT_FIXED      = '0;
    ERR_INSERT     = 1'b0;
    ERR_LANE_MASK  = '0;
    ERR_BURST      = '0;
    clear_stats();
    nxt = '0;
    step(2);
    check("rst_data",  TX_DATA,  80'h0);
    check("rst_valid", TX_VALID, 1'b0);
    check("rst_busy",  ERR_BUSY, 1'b0);
    check("rst_errcnt", ERR_CNT, 16'h0);

    // T1: counter mode, link comes up after enable
    TX_RST_N = 1'b1;
    PAT_EN   = 1'b1;
    step(2);
    check("t1_no_init_valid", TX_VALID, 1'b0);
    check("t1_no_init_data",  TX_DATA,  80'h0);
    LVDS_INIT_DONE = 1'b1;
    step(1);
    check("t1_first_valid", TX_VALID, 1'b1);
    check("t1_first_l0",    lane(0),  8'h00);
    check("t1_first_l9",    lane(9),  8'h09);
    step(1);
    check("t1_second_l0",   lane(0),  8'h01);
    step(254);
    check("t1_ff_l0",       lane(0),  8'hFF);
    check("t1_ff_l9",       lane(9),  8'h08);
    step(1);
    check("t1_wrap_l0",     lane(0),  8'h00);
    LVDS_INIT_DONE = 1'b0;
    step(1);
    check("t1_hold_valid",  TX_VALID, 1'b0);
    check("t1_hold_l0",     lane(0),  8'h00);
    check("t1_hold_l5",     lane(5),  8'h05);

    // T2: PRBS7, selected while idle
    PAT_MODE = 2'd1;
    step(1);
    LVDS_INIT_DONE = 1'b1;
    step(1);
    check("t2_first_valid", TX_VALID, 1'b1);
    check("t2_first_l0",    lane(0),  8'h02);
    check("t2_first_l1",    lane(1),  8'h04);
    zeros = 0;
    for (int k = 1; k <= 127; k++) begin
      step(1);
      for (int i = 0; i < LANES; i++) if (lane(i) == 8'h00) zeros++;
    end
    check("t2_period_l0",   lane(0),  8'h02);
    step(1);
    check("t2_second_l0",   lane(0),  8'h0C);
    check("t2_zero_words",  zeros,    0);

    // T3: walking one, then switch to counter mid-run
    PAT_MODE = 2'd3;
    step(1);
    check("t3_walk0_l0",    lane(0),  8'h01);
    check("t3_walk0_l9",    lane(9),  8'h02);
    step(7);
    check("t3_walk7_l0",    lane(0),  8'h80);
    check("t3_walk7_l9",    lane(9),  8'h01);
    step(1);
    check("t3_walk8_l0",    lane(0),  8'h01);
    PAT_MODE = 2'd0;
    step(1);
    check("t3_restart_l0",  lane(0),  8'h00);
    check("t3_restart_l9",  lane(9),  8'h09);
    nxt = 8'h01;

    // T4: 3-word burst on lane 2
    clear_stats();
    ERR_LANE_MASK = 10'h004;
    ERR_BURST     = 4'd2;
    pulse();
    wait_busy(1'b1, 10, "t4_busy_rise");
    wait_busy(1'b0, 20, "t4_busy_fall");
    tick();
    tick();
    check("t4_corr_l2",     corr[2],           3);
    check("t4_corr_other",  sum_corr() - corr[2], 0);
    check("t4_bad",         bad,               0);
    check("t4_errcnt",      ERR_CNT,           16'd3);

    // T5: request during a busy burst is ignored
    clear_stats();
    ERR_LANE_MASK = 10'h201;
    ERR_BURST     = 4'd7;
    pulse();
    wait_busy(1'b1, 10, "t5_busy_rise");
    ERR_LANE_MASK = 10'h002;
    pulse();
    wait_busy(1'b0, 30, "t5_busy_fall");
    busy_seen = 0;
    repeat (8) tick();
    check("t5_no_rearm",    busy_seen,         1'b0);
    check("t5_corr_l0",     corr[0],           8);
    check("t5_corr_l9",     corr[9],           8);
    check("t5_corr_l1",     corr[1],           0);
    check("t5_bad",         bad,               0);
    check("t5_errcnt",      ERR_CNT,           16'd19);

    // T5b: empty mask request is ignored
    clear_stats();
    ERR_LANE_MASK = '0;
    pulse();
    repeat (8) tick();
    check("t5_mask0_busy",  busy_seen,         1'b0);
    check("t5_mask0_corr",  sum_corr(),        0);
    check("t5_mask0_errcnt", ERR_CNT,          16'd19);

    // T6: burst frozen while disabled, resumes with the remaining count
    clear_stats();
    ERR_LANE_MASK = 10'h010;
    ERR_BURST     = 4'd5;
    pulse();
    wait_busy(1'b1, 10, "t6_busy_rise");
    tick();
    tick();
    PAT_EN = 1'b0;
    repeat (5) tick();
    check("t6_frozen_busy",  ERR_BUSY,         1'b1);
    check("t6_frozen_valid", TX_VALID,         1'b0);
    check("t6_frozen_errcnt", ERR_CNT,         16'd21);
    PAT_EN = 1'b1;
    wait_busy(1'b0, 30, "t6_busy_fall");
    check("t6_corr_l4",     corr[4],           6);
    check("t6_corr_other",  sum_corr() - corr[4], 0);
    check("t6_bad",         bad,               0);
    check("t6_errcnt",      ERR_CNT,           16'd25);

    // T6b: reset in the middle of a burst
    ERR_LANE_MASK = 10'h001;
    ERR_BURST     = 4'd15;
    pulse();
    wait_busy(1'b1, 10, "t6r_busy_rise");
    tick();
    TX_RST_N = 1'b0;
    #1;
    check("t6r_data",       TX_DATA,           80'h0);
    check("t6r_valid",      TX_VALID,          1'b0);
    check("t6r_busy",       ERR_BUSY,          1'b0);
    check("t6r_errcnt",     ERR_CNT,           16'h0);
    @(negedge TX_CLK);
    TX_RST_N = 1'b1;
    step(1);
    check("t6r_first_l0",   lane(0),           8'h00);
    check("t6r_first_l9",   lane(9),           8'h09);
    clear_stats();
    nxt = 8'h01;
    repeat (20) tick();
    check("t6r_no_burst",   busy_seen,         1'b0);
    check("t6r_clean",      sum_corr() + bad,  0);
    check("t6r_errcnt_end", ERR_CNT,           16'h0);

    // Fixed word mode samples PAT_FIXED every run cycle
    PAT_MODE  = 2'd2;
    PAT_FIXED = 8'hA5;
    step(1);
    check("fix_l0",         lane(0),           8'hA5);
    check("fix_l9",         lane(9),           8'hA5);
    PAT_FIXED = 8'h3C;
    step(1);
    check("fix_update_l3",  lane(3),           8'h3C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
